// File: rtl/jk_bank_sequencer.sv
// Command sequencer for a bank of external JK flip-flops: drives J/K from a latched
// opcode/operand and the bank's Q feedback, for one cycle or a counted run of steps.
module jk_bank_sequencer #(
    parameter int N = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         cmd_valid_i,
    output logic         cmd_ready_o,
    input  logic [2:0]   cmd_op_i,
    input  logic [N-1:0] cmd_arg_i,
    input  logic         abort_i,
    input  logic [N-1:0] q_i,
    output logic [N-1:0] j_o,
    output logic [N-1:0] k_o,
    output logic         busy_o,
    output logic         done_o
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_EXEC = 1'b1
    } state_t;

    localparam logic [2:0] OP_CLEAR  = 3'b001;
    localparam logic [2:0] OP_SET    = 3'b010;
    localparam logic [2:0] OP_LOAD   = 3'b011;
    localparam logic [2:0] OP_TOGGLE = 3'b100;
    localparam logic [2:0] OP_UP     = 3'b101;
    localparam logic [2:0] OP_DOWN   = 3'b110;

    localparam logic [N-1:0] CNT_ONE = N'(1);

    state_t       state_q, state_d;
    logic [2:0]   op_q, op_d;
    logic [N-1:0] arg_q, arg_d;
    logic [N-1:0] cnt_q, cnt_d;
    logic         done_q, done_d;

    // Per-bit toggle enables for counting: bit i flips when all lower bits are 1 (up) or 0 (down).
    logic [N-1:0] up_en;
    logic [N-1:0] dn_en;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_cnt_en
            if (gi == 0) begin : g_lsb
                assign up_en[gi] = 1'b1;
                assign dn_en[gi] = 1'b1;
            end else begin : g_upper
                assign up_en[gi] = &q_i[gi-1:0];
                assign dn_en[gi] = ~|q_i[gi-1:0];
            end
        end
    endgenerate

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        arg_d       = arg_q;
        cnt_d       = cnt_q;
        done_d      = 1'b0;
        cmd_ready_o = 1'b0;
        busy_o      = 1'b0;
        j_o         = '0;
        k_o         = '0;

        case (state_q)
            S_IDLE: begin
                // Reset is asynchronous, so ready must also drop combinationally while it is held.
                cmd_ready_o = ~rst_i;
                if (cmd_valid_i && !rst_i) begin
                    op_d    = cmd_op_i;
                    arg_d   = cmd_arg_i;
                    state_d = S_EXEC;
                    if ((cmd_op_i == OP_UP || cmd_op_i == OP_DOWN) && cmd_arg_i != '0) begin
                        cnt_d = cmd_arg_i;
                    end else begin
                        cnt_d = CNT_ONE;
                    end
                end
            end
            S_EXEC: begin
                busy_o = 1'b1;
                if (abort_i) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    case (op_q)
                        OP_CLEAR:  k_o = '1;
                        OP_SET:    j_o = '1;
                        OP_LOAD: begin
                            j_o = arg_q;
                            k_o = ~arg_q;
                        end
                        OP_TOGGLE: begin
                            j_o = arg_q;
                            k_o = arg_q;
                        end
                        OP_UP: begin
                            if (arg_q != '0) begin
                                j_o = up_en;
                                k_o = up_en;
                            end
                        end
                        OP_DOWN: begin
                            if (arg_q != '0) begin
                                j_o = dn_en;
                                k_o = dn_en;
                            end
                        end
                        default: begin
                            j_o = '0;
                            k_o = '0;
                        end
                    endcase
                    cnt_d = cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            arg_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            arg_q   <= arg_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    assign done_o = done_q;

endmodule
